soc_wb_init: RTL and testbench

SOC_WB_INIT -- requirements
Module: soc_wb_init

---
 rtl/soc_wb_init.sv | 173 +++++++++++++++++
 tb/tb_soc_wb_init.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_wb_init.sv
// Wishbone classic initiator: single outstanding command, retry on rty, optional watchdog.
// Optional feature: define SOC_WB_INIT_TIMEOUT_EN to enable the per-attempt bus watchdog.
`timescale 1ns/1ps
module soc_wb_init #(
  parameter int unsigned RETRY_MAX = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic [1:0]  rsp_status_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, GAP = 2'd2, RESP = 2'd3} state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
`ifdef SOC_WB_INIT_TIMEOUT_EN
  localparam logic [1:0] ST_TMO = 2'b11;
`endif

  if (RETRY_MAX > 15) begin : g_bad_retry
    $error("soc_wb_init: RETRY_MAX must be 0..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("soc_wb_init: TIMEOUT must be 1..65535");
  end

  state_t      r_state;
  logic [3:0]  r_retry;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic        r_cyc;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_dat;
  logic [1:0]  r_rsp_status;
`ifdef SOC_WB_INIT_TIMEOUT_EN
  logic [15:0] r_wdog;
`endif

  logic        w_term;
  logic        w_retry;
  logic [1:0]  w_status;
  logic [31:0] w_rdat;

  // Resolve what the current BUS cycle ends with: err > ack > rty (> watchdog).
  always_comb begin
    w_term   = 1'b0;
    w_retry  = 1'b0;
    w_status = ST_OK;
    w_rdat   = '0;
    if (wb_err_i) begin
      w_term   = 1'b1;
      w_status = ST_ERR;
    end else if (wb_ack_i) begin
      w_term   = 1'b1;
      w_status = ST_OK;
      w_rdat   = wb_dat_i;
    end else if (wb_rty_i) begin
      if (r_retry < 4'(RETRY_MAX)) begin
        w_retry = 1'b1;
      end else begin
        w_term   = 1'b1;
        w_status = ST_RTY;
      end
`ifdef SOC_WB_INIT_TIMEOUT_EN
    end else if (r_wdog == 16'(TIMEOUT - 1)) begin
      w_term   = 1'b1;
      w_status = ST_TMO;
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= IDLE;
      r_retry      <= '0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_sel        <= '0;
      r_we         <= 1'b0;
      r_cyc        <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_dat    <= '0;
      r_rsp_status <= ST_OK;
`ifdef SOC_WB_INIT_TIMEOUT_EN
      r_wdog       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid_i) begin
            r_adr   <= cmd_adr_i;
            r_dat   <= cmd_dat_i;
            r_sel   <= cmd_sel_i;
            r_we    <= cmd_we_i;
            r_retry <= '0;
            r_cyc   <= 1'b1;
            r_state <= BUS;
`ifdef SOC_WB_INIT_TIMEOUT_EN
            r_wdog  <= '0;
`endif
          end
        end
        BUS: begin
          if (w_term) begin
            r_cyc        <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= w_status;
            r_rsp_dat    <= w_rdat;
            r_state      <= RESP;
          end else if (w_retry) begin
            r_cyc   <= 1'b0;
            r_retry <= r_retry + 4'd1;
            r_state <= GAP;
`ifdef SOC_WB_INIT_TIMEOUT_EN
          end else begin
            r_wdog <= r_wdog + 16'd1;
`endif
          end
        end
        GAP: begin
          // One idle cycle between attempts; address/data registers are untouched.
          r_cyc   <= 1'b1;
          r_state <= BUS;
`ifdef SOC_WB_INIT_TIMEOUT_EN
          r_wdog  <= '0;
`endif
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = (r_state == IDLE) && !wb_rst_i;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_dat_o    = r_rsp_dat;
  assign rsp_status_o = r_rsp_status;
  assign wb_adr_o     = r_adr;
  assign wb_dat_o     = r_dat;
  assign wb_sel_o     = r_sel;
  assign wb_we_o      = r_we;
  assign wb_cyc_o     = r_cyc;
  assign wb_stb_o     = r_cyc;

endmodule

// File: tb/tb_soc_wb_init.sv
// Self-checking bench for soc_wb_init: scripted/random responder against an outcome model.
`timescale 1ns/1ps
module tb_soc_wb_init;
  localparam int RMAX = 3;
  localparam int TMO  = 16;
  localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_ACKERR = 3, K_NONE = 4, K_ACKRTY = 5, K_ALL = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        cmd_ready, rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic [31:0] wb_adr, wb_dat_o;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  int          att_n;
  int          att_wait [16];
  int          att_kind [16];
  logic [31:0] att_rdat [16];

  always #5 clk = ~clk;

  soc_wb_init #(.RETRY_MAX(RMAX), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_status_o(rsp_status),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty)
  );

  // Outcome of a scripted responder: attempts made, final status and response data.
  function automatic void model(output int runs, output logic [1:0] st, output logic [31:0] d);
    runs = att_n; st = 2'b00; d = '0;
    for (int i = 0; i < att_n; i++) begin
      int k;
      k = att_kind[i];
      if (k == K_ERR || k == K_ACKERR || k == K_ALL) begin
        runs = i + 1; st = 2'b01; d = '0; return;
      end
      if (k == K_ACK || k == K_ACKRTY) begin
        runs = i + 1; st = 2'b00; d = att_rdat[i]; return;
      end
      if (k == K_NONE) begin
        runs = i + 1; st = 2'b11; d = '0; return;
      end
      if (i >= RMAX) begin
        runs = i + 1; st = 2'b10; d = '0; return;
      end
    end
  endfunction

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    {wb_ack, wb_err, wb_rty} = 3'b000;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic run_txn(input string nm, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
    int runs, run_len, low_len, att, cyc_cnt, d, exp_len;
    int highs[$];
    int lows[$];
    logic [1:0]  est, hold_st;
    logic [31:0] edat, hold_dat;
    bit stable_ok, rsp_ok, done, hung;
    model(runs, est, edat);
    run_len = 0; low_len = 0; att = 0; cyc_cnt = 0;
    stable_ok = 1'b1; rsp_ok = 1'b1; done = 1'b0; hung = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL %s idle_ready: got %b want 1", nm, cmd_ready); end
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
    while (!done) begin
      if (wb_cyc !== 1'b1 && run_len > 0) begin highs.push_back(run_len); run_len = 0; low_len = 0; end
      if (rsp_valid === 1'b1) begin
        done = 1'b1;
      end else begin
        {wb_ack, wb_err, wb_rty} = 3'b000;
        wb_dat_i = $urandom;
        if (wb_cyc === 1'b1) begin
          if (run_len == 0) begin
            if (att > 0) lows.push_back(low_len);
            att++;
          end
          run_len++;
          if (wb_stb !== 1'b1 || wb_adr !== adr || wb_dat_o !== dat || wb_sel !== sel ||
              wb_we !== we || cmd_ready !== 1'b0) stable_ok = 1'b0;
          if (att <= att_n && att_kind[att-1] != K_NONE && run_len - 1 == att_wait[att-1]) begin
            wb_dat_i = att_rdat[att-1];
            case (att_kind[att-1])
              K_ACK:    wb_ack = 1'b1;
              K_ERR:    wb_err = 1'b1;
              K_RTY:    wb_rty = 1'b1;
              K_ACKERR: {wb_ack, wb_err} = 2'b11;
              K_ACKRTY: {wb_ack, wb_rty} = 2'b11;
              K_ALL:    {wb_ack, wb_err, wb_rty} = 3'b111;
              default:  ;
            endcase
          end
        end else begin
          low_len++;
          if (wb_stb !== 1'b0 || cmd_ready !== 1'b0) stable_ok = 1'b0;
          {wb_ack, wb_err, wb_rty} = 3'($urandom);
        end
        cyc_cnt++;
        if (cyc_cnt > 3000) begin done = 1'b1; hung = 1'b1; end
        else @(negedge clk);
      end
    end
    n_cmp++;
    if (hung) begin
      n_bad++; $display("FAIL %s response_wait: no rsp_valid within 3000 cycles", nm);
      pulse_reset();
      return;
    end
    if (att !== runs) begin n_bad++; $display("FAIL %s attempts: got %0d want %0d", nm, att, runs); end
    for (int i = 0; i < highs.size() && i < att_n; i++) begin
      exp_len = (att_kind[i] == K_NONE) ? TMO : att_wait[i] + 1;
      n_cmp++;
      if (highs[i] !== exp_len) begin n_bad++; $display("FAIL %s cyc_len[%0d]: got %0d want %0d", nm, i, highs[i], exp_len); end
    end
    for (int i = 0; i < lows.size(); i++) begin
      n_cmp++;
      if (lows[i] !== 1) begin n_bad++; $display("FAIL %s gap_len[%0d]: got %0d want 1", nm, i, lows[i]); end
    end
    n_cmp++;
    if (!stable_ok) begin n_bad++; $display("FAIL %s bus_stable: outputs changed or cmd_ready high during transfer", nm); end
    // Hold the response for a few cycles with noise on the termination lines.
    hold_st = rsp_status; hold_dat = rsp_dat;
    d = $urandom_range(0, 3);
    for (int i = 0; i < d; i++) begin
      {wb_ack, wb_err, wb_rty} = 3'($urandom);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_status !== hold_st || rsp_dat !== hold_dat ||
          cmd_ready !== 1'b0 || wb_cyc !== 1'b0 || wb_stb !== 1'b0) rsp_ok = 1'b0;
    end
    n_cmp++;
    if (!rsp_ok) begin n_bad++; $display("FAIL %s rsp_hold: response not stable while waiting", nm); end
    n_cmp++;
    if (rsp_status !== est) begin n_bad++; $display("FAIL %s status: got %b want %b", nm, rsp_status, est); end
    if (!(we && est == 2'b00)) begin
      n_cmp++;
      if (rsp_dat !== edat) begin n_bad++; $display("FAIL %s rsp_dat: got %h want %h", nm, rsp_dat, edat); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    {wb_ack, wb_err, wb_rty} = 3'b000;
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s after_handshake: rsp_valid=%b cmd_ready=%b want 0/1", nm, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    logic [31:0] z;
    rst = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'hDEAD_BEEF; cmd_dat = 32'h1234_5678;
    cmd_sel = 4'hF; {wb_ack, wb_err, wb_rty} = 3'b111; wb_dat_i = 32'hFFFF_FFFF; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    z = '0;
    n_cmp++;
    if ({wb_adr, wb_dat_o} !== {z, z} || wb_sel !== 4'h0) begin
      n_bad++; $display("FAIL reset_bus_data: adr=%h dat=%h sel=%h want 0", wb_adr, wb_dat_o, wb_sel);
    end
    n_cmp++;
    if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin
      n_bad++; $display("FAIL reset_bus_ctl: cyc/stb/we=%b want 000", {wb_cyc, wb_stb, wb_we});
    end
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_dat !== z || rsp_status !== 2'b00) begin
      n_bad++; $display("FAIL reset_rsp: valid=%b dat=%h status=%b want 0", rsp_valid, rsp_dat, rsp_status);
    end
    n_cmp++;
    if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
    rst = 1'b0; cmd_valid = 1'b0; {wb_ack, wb_err, wb_rty} = 3'b000; rsp_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || wb_cyc !== 1'b0) begin
      n_bad++; $display("FAIL release_ready: cmd_ready=%b cyc=%b want 1/0", cmd_ready, wb_cyc);
    end
  endtask

  task automatic test_read_wait();
    att_n = 1; att_kind[0] = K_ACK; att_wait[0] = 2; att_rdat[0] = 32'hA5A5_0001;
    run_txn("read_wait2", 1'b0, 32'h0100_0004, $urandom, 4'hF);
  endtask

  task automatic test_write_imm();
    att_n = 1; att_kind[0] = K_ACK; att_wait[0] = 0; att_rdat[0] = $urandom;
    run_txn("write_imm", 1'b1, 32'h0000_0008, 32'h0000_00FF, 4'hF);
  endtask

  task automatic test_retry();
    att_n = RMAX + 1;
    for (int i = 0; i < att_n; i++) begin
      att_kind[i] = K_RTY; att_wait[i] = $urandom_range(0, 3); att_rdat[i] = $urandom;
    end
    run_txn("retry_exhaust", 1'b0, 32'h0000_0040, $urandom, 4'h3);
    att_n = 3;
    for (int i = 0; i < 3; i++) begin
      att_kind[i] = (i < 2) ? K_RTY : K_ACK; att_wait[i] = $urandom_range(0, 3); att_rdat[i] = 32'hC0DE_0000 + i;
    end
    run_txn("retry_then_ack", 1'b0, 32'h0000_0044, $urandom, 4'hC);
  endtask

  task automatic test_priority();
    att_n = 1; att_kind[0] = K_ACKERR; att_wait[0] = 1; att_rdat[0] = 32'h5555_AAAA;
    run_txn("ack_err_same", 1'b0, 32'h0000_0100, $urandom, 4'hF);
    att_kind[0] = K_ACKRTY; att_rdat[0] = 32'h1357_9BDF;
    run_txn("ack_rty_same", 1'b0, 32'h0000_0104, $urandom, 4'hF);
    att_kind[0] = K_ALL; att_wait[0] = 0;
    run_txn("all_three", 1'b1, 32'h0000_0108, $urandom, 4'h1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      att_n = RMAX + 1;
      for (int i = 0; i < att_n; i++) begin
        int r;
        r = $urandom_range(0, 9);
        att_kind[i] = (r < 4) ? K_RTY : (r < 6) ? K_ACK : (r == 6) ? K_ERR :
                      (r == 7) ? K_ACKERR : (r == 8) ? K_ACKRTY : K_ALL;
        att_wait[i] = $urandom_range(0, 4);
        att_rdat[i] = $urandom;
      end
      run_txn("random", 1'($urandom), $urandom, $urandom, 4'($urandom));
    end
  endtask

  task automatic test_reset_mid(input int hold);
    int hi;
    bit quiet;
    hi = 0; quiet = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0000_2000; cmd_dat = '0; cmd_sel = 4'hF;
    {wb_ack, wb_err, wb_rty} = 3'b000;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (wb_cyc === 1'b1 && wb_stb === 1'b1 && rsp_valid === 1'b0) hi++;
      @(negedge clk);
    end
    n_cmp++;
    if (hi !== hold) begin n_bad++; $display("FAIL hold_cyc: got %0d cycles high want %0d", hi, hold); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({wb_cyc, wb_stb, rsp_valid, cmd_ready} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_mid: cyc/stb/rsp_valid/cmd_ready=%b want 0000", {wb_cyc, wb_stb, rsp_valid, cmd_ready});
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      {wb_ack, wb_err, wb_rty} = 3'($urandom);
      @(negedge clk);
      if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0 || cmd_ready !== 1'b1) quiet = 1'b0;
    end
    {wb_ack, wb_err, wb_rty} = 3'b000;
    n_cmp++;
    if (!quiet) begin n_bad++; $display("FAIL reset_discard: response or bus activity after reset"); end
    att_n = 1; att_kind[0] = K_ACK; att_wait[0] = 1; att_rdat[0] = 32'hFACE_0033;
    run_txn("after_reset", 1'b0, 32'h0000_2004, $urandom, 4'hF);
  endtask

`ifdef SOC_WB_INIT_TIMEOUT_EN
  task automatic test_timeout();
    att_n = 1; att_kind[0] = K_NONE; att_wait[0] = 0; att_rdat[0] = $urandom;
    run_txn("timeout", 1'b0, 32'h0000_3000, $urandom, 4'hF);
    att_n = 2; att_kind[0] = K_RTY; att_wait[0] = 2; att_kind[1] = K_ACK; att_wait[1] = TMO - 1;
    att_rdat[1] = 32'h0BAD_F00D;
    run_txn("ack_at_timeout", 1'b0, 32'h0000_3004, $urandom, 4'hF);
  endtask
`endif

  initial begin
    test_reset();
    test_read_wait();
    test_write_imm();
    test_retry();
    test_priority();
    test_random();
`ifdef SOC_WB_INIT_TIMEOUT_EN
    test_timeout();
    test_reset_mid(10);
`else
    test_reset_mid(1000);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
